// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the two-requester mux SEL arbiter.
package mux_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN0   = 2'd1,
        ST_OWN1   = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter_hold_cnt.sv
// Tenure counter: saturates at MAX_HOLD, flags sat once the owner has used its last allowed cycle.
module mux_sel_arbiter_hold_cnt #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sat
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] SAT_AT   = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q < HOLD_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q >= SAT_AT);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the shared 2:1 mux SEL line with bounded tenure and a one-cycle handover gap.
// Optional MUX_ARB_LOCK_EN adds a LOCK input that lets the current owner hold past MAX_HOLD.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   REQ0,
    input  logic   REQ1,
`ifdef MUX_ARB_LOCK_EN
    input  logic   LOCK,
`endif
    output logic   GNT0,
    output logic   GNT1,
    output logic   SEL,
    output logic   BUSY,
    output state_t dbg_state
);

    state_t state_q, state_d;
    logic   gnt0_q, gnt0_d;
    logic   gnt1_q, gnt1_d;
    logic   sel_q, sel_d;
    logic   busy_q, busy_d;
    logic   last_q, last_d;
    logic   cnt_clr, cnt_en, cnt_sat;
    logic   preempt;
    logic   target_req;

    mux_sel_arbiter_hold_cnt #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (cnt_clr),
        .en  (cnt_en),
        .sat (cnt_sat)
    );

`ifdef MUX_ARB_LOCK_EN
    assign preempt = cnt_sat && !LOCK;
`else
    assign preempt = cnt_sat;
`endif

    // In SWITCH the incoming side is whatever SEL already points at.
    assign target_req = (sel_q == SEL_IN1) ? REQ1 : REQ0;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ0 && (!REQ1 || (last_q == SEL_IN1))) begin
                    state_d = ST_OWN0;
                    sel_d   = SEL_IN0;
                    last_d  = SEL_IN0;
                    cnt_clr = 1'b1;
                end else if (REQ1) begin
                    state_d = ST_OWN1;
                    sel_d   = SEL_IN1;
                    last_d  = SEL_IN1;
                    cnt_clr = 1'b1;
                end
            end
            ST_OWN0: begin
                cnt_en = 1'b1;
                if (REQ1 && (!REQ0 || preempt)) begin
                    state_d = ST_SWITCH;
                    sel_d   = SEL_IN1;
                end else if (!REQ0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN1: begin
                cnt_en = 1'b1;
                if (REQ0 && (!REQ1 || preempt)) begin
                    state_d = ST_SWITCH;
                    sel_d   = SEL_IN0;
                end else if (!REQ1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                if (target_req) begin
                    state_d = (sel_q == SEL_IN1) ? ST_OWN1 : ST_OWN0;
                    last_d  = sel_q;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        gnt0_d = (state_d == ST_OWN0);
        gnt1_d = (state_d == ST_OWN1);
        busy_d = gnt0_d || gnt1_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            sel_q   <= SEL_IN0;
            busy_q  <= 1'b0;
            last_q  <= SEL_IN1;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign GNT0      = gnt0_q;
    assign GNT1      = gnt1_q;
    assign SEL       = sel_q;
    assign BUSY      = busy_q;
    assign dbg_state = state_q;

endmodule
